// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and buffer entry type for the instruction fetch unit
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        filled;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: imem request/response and decode handshake bundle
interface instr_fetch_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
    );

endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: in-order imem fetch with PC increment, response buffering and redirect flush
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [31:0]   pc_i,
    output logic          pc_ld_o,
    output logic [31:0]   pc_data_o,
    input  logic          redirect_i,
    input  logic [31:0]   redirect_pc_i,
    instr_fetch_if.master bus
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int UW = PW + 1;
    localparam int DW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int SW = DW + 1;

    fetch_entry_t   ent_q [FIFO_DEPTH];
    fetch_entry_t   head_ent;
    logic [PW-1:0]  alloc_q, fill_q, head_q;
    logic [UW-1:0]  used_q, used_d;
    logic [DW-1:0]  unfilled_q, unfilled_d, drop_q, drop_d;
    logic           req_ok, acc, keep, pop;

    assign head_ent            = ent_q[head_q];
    assign bus.instr_valid     = head_ent.filled && used_q != '0;
    assign bus.instr           = head_ent.instr;
    assign bus.instr_pc        = head_ent.pc;
    assign bus.imem_req_addr   = pc_i;
    assign bus.imem_req_valid  = req_ok;

    // request credit, handshakes, PC load selection and counter next-state
    always_comb begin
        req_ok     = rst_ni && !redirect_i && used_q < UW'(FIFO_DEPTH) &&
                     (SW'(unfilled_q) + SW'(drop_q)) < SW'(MAX_OUTSTANDING);
        acc        = req_ok && bus.imem_req_ready;
        keep       = bus.imem_rsp_valid && drop_q == '0;
        pop        = bus.instr_valid && bus.instr_ready;
        pc_ld_o    = rst_ni && (redirect_i || acc);
        pc_data_o  = !rst_ni ? '0 : redirect_i ? redirect_pc_i : acc ? pc_i + 32'(INSTR_BYTES) : '0;
        used_d     = used_q + UW'(acc) - UW'(pop);
        unfilled_d = unfilled_q + DW'(acc) - DW'(keep);
        drop_d     = redirect_i ? drop_q + unfilled_q - DW'(bus.imem_rsp_valid)
                                : drop_q - DW'(bus.imem_rsp_valid && !keep);
    end

    // ring buffer: allocate on request, fill on kept response, pop on decode; redirect flushes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alloc_q    <= '0;
            fill_q     <= '0;
            head_q     <= '0;
            used_q     <= '0;
            unfilled_q <= '0;
            drop_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) ent_q[i] <= '0;
        end else if (redirect_i) begin
            alloc_q    <= '0;
            fill_q     <= '0;
            head_q     <= '0;
            used_q     <= '0;
            unfilled_q <= '0;
            drop_q     <= drop_d;
        end else begin
            if (acc) begin
                ent_q[alloc_q] <= '{pc: pc_i, instr: '0, filled: 1'b0};
                alloc_q        <= alloc_q + 1'b1;
            end
            if (keep) begin
                ent_q[fill_q].instr  <= bus.imem_rsp_data;
                ent_q[fill_q].filled <= 1'b1;
                fill_q               <= fill_q + 1'b1;
            end
            if (pop) head_q <= head_q + 1'b1;
            used_q     <= used_d;
            unfilled_q <= unfilled_d;
            drop_q     <= drop_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized scoreboard bench for instr_fetch with a queue-based reference model
module tb_instr_fetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        bit          filled;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } req_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic [31:0] pc_q;
    logic [31:0] pc_rst = 32'h0;
    logic        pc_ld;
    logic [31:0] pc_data;
    logic        redirect = 0;
    logic [31:0] redirect_pc = 0;

    exp_t        exp_q [$];
    req_t        mem_q [$];
    int          epoch = 0;
    logic [31:0] mpc = 0;
    int          checks = 0;
    int          failures = 0;
    int          delivered = 0;
    int          drops = 0;
    bit          done = 0;

    instr_fetch_if bus ();

    instr_fetch #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pc_i         (pc_q),
        .pc_ld_o      (pc_ld),
        .pc_data_o    (pc_data),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    // program counter register driven by the fetch unit's load port
    always @(posedge clk or negedge rst_n)
        if (!rst_n) pc_q <= pc_rst;
        else if (pc_ld) pc_q <= pc_data;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reset_outputs_check();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 0);
        chk("rst_pc_ld", 32'(pc_ld), 0);
        chk("rst_pc_data", pc_data, 0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 0);
        chk("rst_instr", bus.instr, 0);
        chk("rst_instr_pc", bus.instr_pc, 0);
    endtask

    // monitor: compare DUT outputs against the reference model mid-cycle
    always @(negedge clk) begin
        bit ev, am, iv;
        if (rst_n && !done) begin
            ev = !redirect && exp_q.size() < 4 && mem_q.size() < 2;
            am = ev && bus.imem_req_ready;
            chk("req_valid", 32'(bus.imem_req_valid), 32'(ev));
            if (ev) chk("req_addr", bus.imem_req_addr, mpc);
            chk("pc_ld", 32'(pc_ld), 32'(redirect || am));
            chk("pc_data", pc_data, redirect ? redirect_pc : am ? mpc + 32'd4 : 32'd0);
            iv = exp_q.size() > 0 && exp_q[0].filled;
            chk("instr_valid", 32'(bus.instr_valid), 32'(iv));
            if (iv) begin
                chk("instr", bus.instr, exp_q[0].ins);
                chk("instr_pc", bus.instr_pc, exp_q[0].pc);
                if (bus.instr_ready && !redirect) begin
                    void'(exp_q.pop_front());
                    delivered++;
                end
            end
        end
    end

    // stimulus, imem responder and model bookkeeping
    initial begin
        int p_redir, p_ready, p_rsp, p_iready;
        bit acc;
        bus.imem_req_ready = 0;
        bus.imem_rsp_valid = 0;
        bus.imem_rsp_data  = 0;
        bus.instr_ready    = 0;
        #1;
        reset_outputs_check();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            if (rst_n) begin
                acc = bus.imem_req_valid && bus.imem_req_ready;
                if (bus.imem_rsp_valid) begin
                    req_t r;
                    r = mem_q.pop_front();
                    if (r.epoch == epoch) begin
                        for (int i = 0; i < exp_q.size(); i++)
                            if (!exp_q[i].filled) begin
                                exp_q[i].filled = 1;
                                break;
                            end
                    end else drops++;
                end
                if (acc) mem_q.push_back('{addr: bus.imem_req_addr, epoch: epoch});
                if (redirect) begin
                    exp_q.delete();
                    epoch++;
                    mpc = redirect_pc;
                end else if (acc) begin
                    exp_q.push_back('{pc: mpc, ins: memfn(mpc), filled: 0});
                    mpc = mpc + 32'd4;
                end
            end
            #1;
            rst_n = 1;
            if (cyc == 2500) begin
                pc_rst = 32'h0000_0200;
                redirect = 0;
                bus.imem_req_ready = 0;
                bus.imem_rsp_valid = 0;
                bus.instr_ready = 0;
                rst_n = 0;
                #1;
                reset_outputs_check();
                exp_q.delete();
                mem_q.delete();
                epoch++;
                mpc = pc_rst;
                continue;
            end
            p_redir  = cyc < 150 ? 0 : 8;
            p_ready  = cyc < 150 ? 100 : 70;
            p_rsp    = cyc < 150 ? 100 : 60;
            p_iready = cyc < 150 ? 100 : (cyc < 400 || (cyc > 2450 && cyc < 2500)) ? 10 : 60;
            redirect = $urandom_range(0, 99) < p_redir;
            redirect_pc = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            bus.imem_req_ready = $urandom_range(0, 99) < p_ready;
            bus.imem_rsp_valid = mem_q.size() > 0 && $urandom_range(0, 99) < p_rsp;
            bus.imem_rsp_data  = bus.imem_rsp_valid ? memfn(mem_q[0].addr) : $urandom;
            bus.instr_ready    = $urandom_range(0, 99) < p_iready;
        end
        @(posedge clk);
        #1 done = 1;
        chk("delivered_enough", 32'(delivered > 500), 1);
        chk("drops_seen", 32'(drops > 10), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
